// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared constants and types for the RAM4096_16bit access controllers.
//   ADDR_W : word address width (4096 words)
//   DATA_W : RAM word width
//   DEPTH  : number of RAM words
//   arb_state_e : controller states (CLEAR is only reachable when the
//                 controller is built with RAM_ARB_CLEAR_EN)
package ram_arb_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4096;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2
// Two-input round-robin arbiter, purely combinational.
//   req      in  2  request per requester
//   last_gnt in  1  index of the requester granted most recently
//   gnt_oh   out 2  one-hot winner (all zero when nothing requested)
// On a tie the requester that was NOT granted last wins.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt_oh
);

  always_comb begin
    gnt_oh = 2'b00;
    case (req)
      2'b01:   gnt_oh = 2'b01;
      2'b10:   gnt_oh = 2'b10;
      2'b11:   gnt_oh = last_gnt ? 2'b01 : 2'b10;
      default: gnt_oh = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram4096_arbiter.sv
// ram4096_arbiter
// Two-port round-robin access controller in front of the single-port
// 4096 x 16 RAM. One access takes two cycles: an IDLE cycle in which the
// requests are sampled and the winner's command latched, then an ACCESS
// cycle driving one RAM command. Read data is registered at the end of the
// ACCESS cycle and flagged with a one-cycle rvalid pulse.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   req/we [1:0]       request and write-enable per requester
//   addr0/1, wdata0/1  command per requester, held until gnt
//   gnt [1:0]          pulse in the ACCESS cycle of the granted requester
//   rvalid [1:0]       pulse when rdata holds that requester's read result
//   rdata              shared read data register
//   busy               high while the post-reset clear sequence runs
//   ram_*              RAM command interface, ram_dout is the RAM read data
//
// Build option: define RAM_ARB_CLEAR_EN to zero-fill all 4096 words after
// every reset (busy high, requests ignored meanwhile). Without it reset goes
// straight to IDLE and busy is tied low.
module ram4096_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  arb_state_e        state_q;
  logic              last_gnt_q;   // index of requester granted last
  logic              cur_q;        // index of requester being served
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        gnt_q;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata_q;

`ifdef RAM_ARB_CLEAR_EN
  logic              busy_q;
  logic [ADDR_W-1:0] clr_cnt_q;
`endif

  // Arbitration on the raw requests; only consumed in IDLE.
  logic [1:0]        win_oh;
  logic              win_idx;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  rr_arbiter_2 u_rr (
    .req      (req),
    .last_gnt (last_gnt_q),
    .gnt_oh   (win_oh)
  );

  assign win_idx   = win_oh[1];
  assign win_we    = win_idx ? we[1]  : we[0];
  assign win_addr  = win_idx ? addr1  : addr0;
  assign win_wdata = win_idx ? wdata1 : wdata0;

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef RAM_ARB_CLEAR_EN
      state_q   <= CLEAR;
      busy_q    <= 1'b1;
      clr_cnt_q <= '0;
`else
      state_q   <= IDLE;
`endif
      last_gnt_q <= 1'b1;        // requester 0 wins the first tie
      cur_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      // gnt and rvalid are single-cycle pulses
      gnt_q    <= '0;
      rvalid_q <= '0;
      case (state_q)
`ifdef RAM_ARB_CLEAR_EN
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
`endif
        IDLE: begin
          if (|req) begin
            state_q <= ACCESS;
            cur_q   <= win_idx;
            we_q    <= win_we;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            gnt_q   <= win_oh;
          end
        end
        ACCESS: begin
          state_q    <= IDLE;
          last_gnt_q <= cur_q;
          if (!we_q) begin
            rdata_q  <= ram_dout;
            rvalid_q <= gnt_q;     // gnt_q is the winner's one-hot here
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM command decoded from registered state and latched command only,
  // so request inputs never reach the RAM pins combinationally.
  always_comb begin
    ram_en    = 1'b0;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    ram_addr  = addr_q;
    ram_din   = wdata_q;
    case (state_q)
      ACCESS: begin
        ram_en    = 1'b1;
        ram_write = we_q;
        ram_read  = ~we_q;
      end
`ifdef RAM_ARB_CLEAR_EN
      CLEAR: begin
        ram_en    = 1'b1;
        ram_write = 1'b1;
        ram_addr  = clr_cnt_q;
        ram_din   = '0;
      end
`endif
      default: ;
    endcase
  end

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

`ifdef RAM_ARB_CLEAR_EN
  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

endmodule

// File: doc/ram4096_arbiter.md
# ram4096_arbiter

Two-port round-robin access controller for the 4096 x 16 word RAM (RAM4096_16bit), sitting between two requesters (e.g. CPU fetch port and data port) and the RAM's single read/write/address/enable interface. Serialises requests, drives one RAM command per access, and returns read data with a valid pulse. Optionally zero-fills the entire RAM after reset.

## Interface
- ADDR_W, 12, RAM word address width (4096 words)
- DATA_W, 16, RAM data width
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  2  request per requester i (bit i)
- we  in  2  1 = write, 0 = read, per requester; valid with req[i]
- addr0, addr1  in  ADDR_W  word address per requester
- wdata0, wdata1  in  DATA_W  write data per requester
- gnt  out  2  one-cycle pulse: request i accepted and executing this cycle
- rvalid  out  2  one-cycle pulse: rdata holds read result for requester i
- rdata  out  DATA_W  read data register, shared by both requesters
- busy  out  1  high while the clear sequence runs
- ram_en, ram_read, ram_write  out  1  RAM chip enable / read / write
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data

## Operation
- States: CLEAR (only with macro), IDLE, ACCESS.
- IDLE: ram_en/read/write = 0. If any req, at the edge latch winner's we/addr/wdata, go ACCESS. No req: stay IDLE.
- Arbitration: one requester active wins; both active -> the one not granted last. last_gnt resets to 1, so requester 0 wins the first tie.
- ACCESS: gnt[winner]=1; ram_en=1, ram_addr/ram_din from latched command, ram_write=we_l, ram_read=~we_l. At the edge: write commits into the RAM; for a read, rdata <= ram_dout and rvalid[winner] pulses the next cycle. last_gnt <= winner. Always return to IDLE.
- Requester protocol: hold req, we, addr, wdata stable from assertion until gnt seen; may drop req or present a new request the cycle after gnt. Requests are sampled only in IDLE.
- rdata holds its value until the next read completes; writes never change rdata or pulse rvalid.
- All RAM outputs decode from registered state/latches only; no combinational path from req/addr/wdata to ram_*.
- Reset values: gnt=0, rvalid=0, rdata=0, ram_en/read/write=0, ram_addr=0, ram_din=0, last_gnt=1, busy per Configuration.
- Reset mid-access: access aborted, no rvalid; a write in progress at the reset edge is not guaranteed. Requester must reissue.

## Timing
- Read: req sampled in IDLE cycle T; gnt and RAM read in T+1; rvalid/rdata in T+2.
- Write: req at T; gnt and RAM write in T+1; data visible to a read issued at T+2 or later.
- Throughput: one access per 2 cycles. Both requesters continuously requesting alternate 0,1,0,1.
- rvalid of one access may coincide with the IDLE sampling of the next; both occur in the same cycle.

## Configuration
- RAM_ARB_CLEAR_EN defined: reset enters CLEAR with busy=1, 12-bit counter=0. Each cycle: ram_en=1, ram_write=1, ram_addr=counter, ram_din=0, counter++. After writing address 4095 (4096 cycles) go IDLE, busy=0. req ignored, gnt=0 throughout. rst during CLEAR restarts at address 0.
- Not defined: reset goes straight to IDLE; busy tied 0; RAM contents undefined until written.

## Structure
- Package ram_arb_pkg: ADDR_W, DATA_W, DEPTH=4096, state enum {CLEAR, IDLE, ACCESS}.
- Sub-module rr_arbiter_2: req[1:0] + last_gnt -> one-hot winner; purely combinational, reused by later multi-port controllers.

## Test plan
- Reset (no macro): outputs 0, next cycle req[0] write addr 0x005 data 0xBEEF -> gnt[0] at T+1 with ram_write=1, ram_addr=0x005; no rvalid.
- Read-back: after above, req[1] read 0x005 -> gnt[1] at T+1, rvalid[1] and rdata=0xBEEF at T+2.
- Tie: both req reads from reset -> gnt order 0,1,0,1 over four accesses; rvalid matches gnt owner.
- Boundary addresses: write 0x000=0x1111, 0xFFF=0xFFFF; read both back exactly, no aliasing.
- RAM_ARB_CLEAR_EN: preload 0x7A3=0x1234, assert rst -> busy=1 for 4096 cycles, req[0] held ignored, then gnt[0]; read 0x7A3 returns 0x0000.
- Reset mid-read: rst in ACCESS cycle -> no rvalid, rdata=0, state IDLE, next request served normally.
